// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU load/store
// path and a debug/loader port. Each access is serialised as IDLE -> GRANT -> DONE.
// The CPU is stalled while it waits. The debug port gets a grant after at most
// STARVE_LIMIT consecutive contended CPU grants.
//
// Ports:
//   clk, rst                                  clock (rising edge), async active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata         CPU request side (held until cpu_ack)
//   cpu_rdata/cpu_ack/cpu_stall               CPU response side (cpu_stall is combinational)
//   dbg_req/dbg_we/dbg_addr/dbg_wdata         debug request side (held until dbg_ack)
//   dbg_rdata/dbg_ack                         debug response side
//   mem_read/mem_write/mem_addr/mem_wdata     to dataMemory
//   mem_rdata                                 from dataMemory (combinational read)
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_GRANT_CPU = 2'd1;
    localparam logic [1:0] S_GRANT_DBG = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] starve_q,    starve_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic          dbg_ack_q,   dbg_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant_cpu,   grant_dbg;

    // Next-state, arbitration and memory-command decode
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        grant_cpu   = 1'b0;
        grant_dbg   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Debug wins when alone, or when the CPU has used up its contended budget
                if (dbg_req && (!cpu_req || (starve_q == CW'(STARVE_LIMIT)))) begin
                    grant_dbg = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end
            end
            S_GRANT_CPU: begin
                cpu_rdata_d = mem_rdata;
                cpu_ack_d   = 1'b1;
                state_d     = S_DONE;
            end
            S_GRANT_DBG: begin
                dbg_rdata_d = mem_rdata;
                dbg_ack_d   = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_cpu) begin
            state_d     = S_GRANT_CPU;
            mem_read_d  = ~cpu_we;
            mem_write_d = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
        end else if (grant_dbg) begin
            state_d     = S_GRANT_DBG;
            mem_read_d  = ~dbg_we;
            mem_write_d = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
        end

        // A CPU grant while debug is waiting counts towards starvation
        if (!dbg_req || grant_dbg) begin
            starve_d = '0;
        end else if (grant_cpu && (starve_q != CW'(STARVE_LIMIT))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

    // Freeze the pipeline from request until the ack cycle
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a small behavioural
// data memory (combinational read, write on rising edge).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        mem_init;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] held_cpu, held_dbg;

    typedef struct {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural data memory: 64 words, word-indexed by byte address
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One uncontended access; called at posedge+1 of an IDLE cycle, returns at
    // posedge+1 of the cycle after the ack with the request dropped.
    task automatic run_xact(input vec_t v);
        if (v.dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        #4;
        chk1("c0_mem_read", mem_read, 1'b0);
        chk1("c0_mem_write", mem_write, 1'b0);
        chk1("c0_cpu_stall", cpu_stall, !v.dbg);
        tick; #4;
        chk1("c1_mem_read", mem_read, !v.we);
        chk1("c1_mem_write", mem_write, v.we);
        chk32("c1_mem_addr", mem_addr, v.addr);
        if (v.we) chk32("c1_mem_wdata", mem_wdata, v.wdata);
        chk1("c1_cpu_ack", cpu_ack, 1'b0);
        chk1("c1_dbg_ack", dbg_ack, 1'b0);
        chk1("c1_cpu_stall", cpu_stall, !v.dbg);
        tick; #4;
        chk1("c2_cpu_ack", cpu_ack, !v.dbg);
        chk1("c2_dbg_ack", dbg_ack, v.dbg);
        chk1("c2_mem_read", mem_read, 1'b0);
        chk1("c2_mem_write", mem_write, 1'b0);
        chk1("c2_cpu_stall", cpu_stall, 1'b0);
        if (v.dbg) begin
            chk32("c2_dbg_rdata", dbg_rdata, v.rdata);
            chk32("c2_cpu_rdata_held", cpu_rdata, held_cpu);
            held_dbg = v.rdata;
        end else begin
            chk32("c2_cpu_rdata", cpu_rdata, v.rdata);
            chk32("c2_dbg_rdata_held", dbg_rdata, held_dbg);
            held_cpu = v.rdata;
        end
        tick;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                dbg   we    addr          wdata         expected rdata
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h12345678};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2,        32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        32'h2};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'hA5A5A5A5};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        32'h2};

        rst = 1'b0; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        held_cpu = 32'h0; held_dbg = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_cpu_ack", cpu_ack, 1'b0);
        chk1("rst_dbg_ack", dbg_ack, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk1("rst_stall_low", cpu_stall, 1'b0);
        cpu_req = 1'b1;
        #1;
        chk1("rst_stall_follows_req", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        mem_init = 1'b0;
        #1 rst = 1'b1;
        tick;

        // Uncontended transactions from the table
        for (int i = 0; i < 11; i++) run_xact(vecs[i]);

        // Contention: both held; 4 CPU grants then 1 debug grant, repeating
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
        for (int c = 0; c < 31; c++) begin
            #4;
            chk1("cont_cpu_ack", cpu_ack,
                 ((c % 15) == 2) || ((c % 15) == 5) || ((c % 15) == 8) || ((c % 15) == 11));
            chk1("cont_dbg_ack", dbg_ack, (c % 15) == 14);
            chk1("cont_no_overlap", mem_read & mem_write, 1'b0);
            if ((c % 15) == 14) chk32("cont_dbg_rdata", dbg_rdata, 32'h2);
            if ((c % 15) == 2)  chk32("cont_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);
            tick;
        end
        // Requests dropped while a CPU access is in GRANT: it still completes
        cpu_req = 1'b0; dbg_req = 1'b0;
        #4;
        chk1("drop_grant_read", mem_read, 1'b1);
        tick; #4;
        chk1("drop_cpu_ack", cpu_ack, 1'b1);
        chk1("drop_dbg_ack", dbg_ack, 1'b0);
        chk32("drop_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);
        tick; #4;
        chk1("drop_idle_ack", cpu_ack | dbg_ack, 1'b0);
        tick;

        // Reset in the middle of a debug write grant
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'hCAFEF00D;
        tick; #1;
        chk1("rstw_mem_write_before", mem_write, 1'b1);
        chk32("rstw_mem_addr_before", mem_addr, 32'h30);
        #2 rst = 1'b0;
        #1;
        chk1("rstw_mem_write_dropped", mem_write, 1'b0);
        chk1("rstw_mem_read", mem_read, 1'b0);
        chk32("rstw_mem_addr", mem_addr, 32'h0);
        chk32("rstw_dbg_rdata", dbg_rdata, 32'h0);
        chk32("rstw_cpu_rdata", cpu_rdata, 32'h0);
        chk1("rstw_dbg_ack", dbg_ack, 1'b0);
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        #1;
        chk1("rstw_stall", cpu_stall, 1'b1);
        @(posedge clk); #1;
        chk1("rstw_dbg_ack_held", dbg_ack, 1'b0);
        chk32("rstw_no_partial_write", mem[12], 32'h0);
        #1 rst = 1'b1;
        // First access after release shows the FSM is back in IDLE
        #3;
        chk1("rel_c0_ack", cpu_ack | dbg_ack, 1'b0);
        tick; #4;
        chk1("rel_c1_mem_read", mem_read, 1'b1);
        chk32("rel_c1_mem_addr", mem_addr, 32'h10);
        chk1("rel_c1_dbg_ack", dbg_ack, 1'b0);
        tick; #4;
        chk1("rel_c2_cpu_ack", cpu_ack, 1'b1);
        chk1("rel_c2_dbg_ack", dbg_ack, 1'b0);
        chk32("rel_c2_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);
        tick;
        cpu_req = 1'b0;

        // Idle: no requests for 20 cycles
        for (int c = 0; c < 20; c++) begin
            #4;
            chk1("idle_mem_read", mem_read, 1'b0);
            chk1("idle_mem_write", mem_write, 1'b0);
            chk1("idle_acks", cpu_ack | dbg_ack, 1'b0);
            tick;
        end
        chk32("idle_mem12_untouched", mem[12], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
